rx_byte_viewer: RTL and testbench
=================================

Name: rx_byte_viewer

Overview:
Parametrised receive-side byte buffer plus display register, sitting between a UART receiver and a user-facing output such as LEDs. It stores received words in a 2^LGFLEN-deep circular buffer. Each pulse on i_next latches the oldest stored word into a held display register. Over its predecessor it adds configurable width, depth and empty value, an overwrite-oldest mode, synchronous flush, fill level, a sticky overflow flag and a saturating drop counter.

Parameters:
DW, 8, data word width in bits
LGFLEN, 3, log2 of buffer depth (depth = 2^LGFLEN; legal range 1..8)
OVERWRITE, 0, full-buffer policy: 0 = drop incoming word, 1 = overwrite oldest word
EMPTY_VAL, 0 (DW bits), value shown on o_data when i_next finds the buffer empty, and after reset or clear
CW, 8, width of the drop counter

Ports:
i_clk  input  1  system clock; all state changes on its rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_wr  input  1  one-cycle write strobe from the receiver
i_data  input  DW  word to store, sampled when i_wr=1
i_next  input  1  one-cycle request to pop the oldest word into the display register (for example, a debounced button-down pulse)
i_clear  input  1  synchronous flush
o_data  output  DW  display register
o_valid  output  1  1 when o_data holds a popped word; 0 when it holds EMPTY_VAL
o_fill  output  LGFLEN+1  number of stored words, 0..2^LGFLEN
o_empty  output  1  o_fill == 0
o_full  output  1  o_fill == 2^LGFLEN
o_ovf  output  1  sticky: set when any word was dropped or overwritten
o_drops  output  CW  saturating count of dropped or overwritten words

Behaviour:
- Reset (i_rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, o_fill=0, o_empty=1, o_full=0, o_ovf=0, o_drops=0, o_data=EMPTY_VAL, o_valid=0. Memory contents are don't-care. Reset asserted mid-operation discards all state immediately.
- Pointers are LGFLEN bits and wrap modulo depth. o_fill is a separate registered counter. o_empty and o_full are decoded from o_fill.
- Priority in each cycle: i_clear > {i_wr, i_next}.
- i_clear=1: pointers, o_fill, o_ovf and o_drops go to 0; o_data goes to EMPTY_VAL; o_valid goes to 0. Any i_wr or i_next in the same cycle is ignored.
- Pop (i_next=1, fill>0 at the clock edge): o_data <= mem[rd_ptr] and o_valid <= 1 on the next edge, i.e. 1-cycle latency. rd_ptr advances by 1 and fill decreases by 1.
- Pop on empty (i_next=1, fill==0): o_data <= EMPTY_VAL and o_valid <= 0. There is no bypass: a simultaneous i_wr is stored but not displayed.
- Between pops, o_data and o_valid hold their values.
- Write with buffer not full: mem[wr_ptr] <= i_data, wr_ptr advances by 1, fill increases by 1.
- Write with buffer full and i_next=0:
  - OVERWRITE=0: the word is discarded; pointers and fill are unchanged.
  - OVERWRITE=1: mem[wr_ptr] <= i_data and both pointers advance; fill stays at depth, so the oldest word is lost.
  - Both modes: o_ovf <= 1 and o_drops increments, saturating at 2^CW-1.
- Write with buffer full and i_next=1: the pop reads the old head, then the write is stored. Fill stays at depth. This is not an overflow.
- Write and pop on a non-empty, non-full buffer: both take effect and fill is unchanged.
- Read-before-write on the same address only occurs in the full+pop+write case. The pop must return the pre-write content.
- o_ovf and o_drops clear only on reset or i_clear.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 and pulse i_next three times -> o_data 0x41, 0x42, 0x43 each one cycle after its pulse, o_valid=1; o_fill goes 3→0; o_empty=1 at the end.
- On an empty buffer, pulse i_next -> o_data=EMPTY_VAL, o_valid=0, o_drops=0. Pulse i_next and write 0x55 in the same cycle -> o_data=EMPTY_VAL, o_fill=1; the next i_next returns 0x55.
- OVERWRITE=0, LGFLEN=3: write 0x00..0x09 -> o_full=1, o_ovf=1, o_drops=2; eight pops return 0x00..0x07.
- OVERWRITE=1, LGFLEN=3: write 0x00..0x09 -> o_drops=2; eight pops return 0x02..0x09.
- Full buffer holding 0x10..0x17, then pop and write 0xAA in the same cycle -> o_data=0x10, o_fill=8, o_ovf=0; the next seven pops return 0x11..0x17, and the eighth returns 0xAA.
- With fill=5, o_ovf=1 and o_drops=3, assert i_clear together with i_wr -> all counters 0, o_data=EMPTY_VAL. Then pull i_rst_n low asynchronously mid-stream -> outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/rx_byte_viewer_if.sv
// Bus bundle for rx_byte_viewer: receiver write/pop/flush controls and the display/status outputs.
interface rx_byte_viewer_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LGFLEN = 3,
  parameter int unsigned CW     = 8
);
  logic              i_wr;
  logic [DW-1:0]     i_data;
  logic              i_next;
  logic              i_clear;
  logic [DW-1:0]     o_data;
  logic              o_valid;
  logic [LGFLEN:0]   o_fill;
  logic              o_empty;
  logic              o_full;
  logic              o_ovf;
  logic [CW-1:0]     o_drops;

  modport master (
    output i_wr, i_data, i_next, i_clear,
    input  o_data, o_valid, o_fill, o_empty, o_full, o_ovf, o_drops
  );

  modport slave (
    input  i_wr, i_data, i_next, i_clear,
    output o_data, o_valid, o_fill, o_empty, o_full, o_ovf, o_drops
  );
endinterface

// File: rtl/rx_byte_viewer.sv
// Receive-side circular word buffer with a held display register, fill level,
// sticky overflow flag and saturating drop counter.
module rx_byte_viewer #(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    LGFLEN    = 3,
  parameter bit             OVERWRITE = 1'b0,
  parameter logic [DW-1:0]  EMPTY_VAL = {DW{1'b0}},
  parameter int unsigned    CW        = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rx_byte_viewer_if.slave bus
);

  localparam int unsigned      DEPTH_I    = 1 << LGFLEN;
  localparam logic [LGFLEN:0]  DEPTH_C    = {1'b1, {LGFLEN{1'b0}}};
  localparam logic [LGFLEN:0]  FILL_ONE_C = (LGFLEN+1)'(1);
  localparam logic [LGFLEN-1:0] PTR_ONE_C = LGFLEN'(1);
  localparam logic [CW-1:0]    DROP_ONE_C = CW'(1);
  localparam logic [CW-1:0]    DROP_MAX_C = {CW{1'b1}};

  logic [DW-1:0]     mem_r [0:DEPTH_I-1];
  logic [LGFLEN-1:0] wr_ptr_r;
  logic [LGFLEN-1:0] rd_ptr_r;
  logic [LGFLEN:0]   fill_r;
  logic              empty_r;
  logic              full_r;
  logic              ovf_r;
  logic [CW-1:0]     drops_r;
  logic [DW-1:0]     data_r;
  logic              valid_r;

  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              ovw_s;
  logic [LGFLEN:0]   fill_nxt_s;

  // Decode this cycle's pop/push/drop actions; flush masks everything.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    ovw_s  = 1'b0;
    if (bus.i_clear) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      pop_s  = bus.i_next && (fill_r != {(LGFLEN+1){1'b0}});
      // A full buffer with a simultaneous pop has room, so only a pop-less write overflows.
      drop_s = bus.i_wr && (fill_r == DEPTH_C) && !bus.i_next;
      ovw_s  = drop_s && OVERWRITE;
      push_s = bus.i_wr && (!drop_s || OVERWRITE);
    end
  end

  // Next fill level; an overwrite pushes without growing the buffer.
  always_comb begin
    fill_nxt_s = fill_r;
    case ({push_s && !ovw_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + FILL_ONE_C;
      2'b01:   fill_nxt_s = fill_r - FILL_ONE_C;
      default: fill_nxt_s = fill_r;
    endcase
  end

  // Storage array; nonblocking write keeps the same-edge pop reading the old word.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.i_data;
    end
  end

  // Pointers, status counters and display register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {LGFLEN{1'b0}};
      rd_ptr_r <= {LGFLEN{1'b0}};
      fill_r   <= {(LGFLEN+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      drops_r  <= {CW{1'b0}};
      data_r   <= EMPTY_VAL;
      valid_r  <= 1'b0;
    end else if (bus.i_clear) begin
      wr_ptr_r <= {LGFLEN{1'b0}};
      rd_ptr_r <= {LGFLEN{1'b0}};
      fill_r   <= {(LGFLEN+1){1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
      drops_r  <= {CW{1'b0}};
      data_r   <= EMPTY_VAL;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s || ovw_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      fill_r  <= fill_nxt_s;
      empty_r <= (fill_nxt_s == {(LGFLEN+1){1'b0}});
      full_r  <= (fill_nxt_s == DEPTH_C);
      if (drop_s) begin
        ovf_r <= 1'b1;
        if (drops_r != DROP_MAX_C) begin
          drops_r <= drops_r + DROP_ONE_C;
        end
      end
      if (bus.i_next) begin
        if (pop_s) begin
          data_r  <= mem_r[rd_ptr_r];
          valid_r <= 1'b1;
        end else begin
          data_r  <= EMPTY_VAL;
          valid_r <= 1'b0;
        end
      end
    end
  end

  assign bus.o_data  = data_r;
  assign bus.o_valid = valid_r;
  assign bus.o_fill  = fill_r;
  assign bus.o_empty = empty_r;
  assign bus.o_full  = full_r;
  assign bus.o_ovf   = ovf_r;
  assign bus.o_drops = drops_r;

endmodule

// File: tb/tb_rx_byte_viewer.sv
// Scoreboard bench for rx_byte_viewer: one drop-mode and one overwrite-mode instance,
// pop results queued at issue time and compared by independent monitors.
module tb_rx_byte_viewer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_byte_viewer_if #(.DW(8), .LGFLEN(3), .CW(8)) bus0 ();
  rx_byte_viewer_if #(.DW(8), .LGFLEN(3), .CW(8)) bus1 ();

  rx_byte_viewer #(.DW(8), .LGFLEN(3), .OVERWRITE(1'b0), .EMPTY_VAL(8'h00), .CW(8))
    dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  rx_byte_viewer #(.DW(8), .LGFLEN(3), .OVERWRITE(1'b1), .EMPTY_VAL(8'h00), .CW(8))
    dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] e0;
  logic [8:0] e1;
  logic chk0_r = 1'b0;
  logic chk1_r = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Note which edges accepted a pop request so the monitor knows when to compare.
  always @(posedge clk) begin
    chk0_r <= rst_n && bus0.i_next && !bus0.i_clear;
    chk1_r <= rst_n && bus1.i_next && !bus1.i_clear;
  end

  // Monitor: compare the display register against the scoreboard one cycle after each pop.
  always @(negedge clk) begin
    if (chk0_r) begin
      if (q0.size() == 0) begin
        check("pop0_unexpected", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("pop0_valid_data", {23'd0, bus0.o_valid, bus0.o_data}, {23'd0, e0});
      end
    end
    if (chk1_r) begin
      if (q1.size() == 0) begin
        check("pop1_unexpected", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("pop1_valid_data", {23'd0, bus1.o_valid, bus1.o_data}, {23'd0, e1});
      end
    end
  end

  task automatic drive(input int u, input logic wr, input logic [7:0] d, input logic nx, input logic cl);
    if (u == 0) begin
      bus0.i_wr = wr; bus0.i_data = d; bus0.i_next = nx; bus0.i_clear = cl;
    end else begin
      bus1.i_wr = wr; bus1.i_data = d; bus1.i_next = nx; bus1.i_clear = cl;
    end
    @(negedge clk);
    bus0.i_wr = 1'b0; bus0.i_next = 1'b0; bus0.i_clear = 1'b0;
    bus1.i_wr = 1'b0; bus1.i_next = 1'b0; bus1.i_clear = 1'b0;
  endtask

  task automatic pop_exp(input int u, input logic v, input logic [7:0] d,
                         input logic wr, input logic [7:0] wd);
    if (u == 0) q0.push_back({v, d});
    else        q1.push_back({v, d});
    drive(u, wr, wd, 1'b1, 1'b0);
  endtask

  task automatic stat(input int u, input string tag, input int fill, input int ovf, input int drops);
    if (u == 0) begin
      check({tag, "_fill"},  32'(bus0.o_fill),  32'(fill));
      check({tag, "_empty"}, 32'(bus0.o_empty), 32'(fill == 0));
      check({tag, "_full"},  32'(bus0.o_full),  32'(fill == 8));
      check({tag, "_ovf"},   32'(bus0.o_ovf),   32'(ovf));
      check({tag, "_drops"}, 32'(bus0.o_drops), 32'(drops));
    end else begin
      check({tag, "_fill"},  32'(bus1.o_fill),  32'(fill));
      check({tag, "_empty"}, 32'(bus1.o_empty), 32'(fill == 0));
      check({tag, "_full"},  32'(bus1.o_full),  32'(fill == 8));
      check({tag, "_ovf"},   32'(bus1.o_ovf),   32'(ovf));
      check({tag, "_drops"}, 32'(bus1.o_drops), 32'(drops));
    end
  endtask

  initial begin
    bus0.i_wr = 1'b0; bus0.i_data = 8'h00; bus0.i_next = 1'b0; bus0.i_clear = 1'b0;
    bus1.i_wr = 1'b0; bus1.i_data = 8'h00; bus1.i_next = 1'b0; bus1.i_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data",  32'(bus0.o_data),  32'h0);
    check("rst_valid", 32'(bus0.o_valid), 32'h0);
    stat(0, "rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write then pop, in order.
    drive(0, 1'b1, 8'h41, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h42, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h43, 1'b0, 1'b0);
    stat(0, "fill3", 3, 0, 0);
    pop_exp(0, 1'b1, 8'h41, 1'b0, 8'h00);
    pop_exp(0, 1'b1, 8'h42, 1'b0, 8'h00);
    pop_exp(0, 1'b1, 8'h43, 1'b0, 8'h00);
    stat(0, "drained", 0, 0, 0);

    // Empty pop, empty pop with simultaneous write (no bypass).
    pop_exp(0, 1'b0, 8'h00, 1'b0, 8'h00);
    stat(0, "emptypop", 0, 0, 0);
    pop_exp(0, 1'b0, 8'h00, 1'b1, 8'h55);
    stat(0, "emptypop_wr", 1, 0, 0);
    pop_exp(0, 1'b1, 8'h55, 1'b0, 8'h00);

    // Drop mode overflow: 10 writes into 8 slots.
    for (int i = 0; i < 10; i++) drive(0, 1'b1, 8'(i), 1'b0, 1'b0);
    stat(0, "drop_full", 8, 1, 2);
    for (int i = 0; i < 8; i++) pop_exp(0, 1'b1, 8'(i), 1'b0, 8'h00);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_data",  32'(bus0.o_data),  32'h0);
    check("clr_valid", 32'(bus0.o_valid), 32'h0);
    stat(0, "clr", 0, 0, 0);

    // Full buffer with same-cycle pop and write: read old head, not an overflow.
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    pop_exp(0, 1'b1, 8'h10, 1'b1, 8'hAA);
    stat(0, "full_popwr", 8, 0, 0);
    for (int i = 1; i < 8; i++) pop_exp(0, 1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
    pop_exp(0, 1'b1, 8'hAA, 1'b0, 8'h00);
    stat(0, "full_popwr_end", 0, 0, 0);

    // Clear wins over a same-cycle write.
    for (int i = 0; i < 11; i++) drive(0, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pop_exp(0, 1'b1, 8'h20 + 8'(i), 1'b0, 8'h00);
    stat(0, "pre_clr", 5, 1, 3);
    drive(0, 1'b1, 8'h99, 1'b0, 1'b1);
    check("clrwr_data",  32'(bus0.o_data),  32'h0);
    check("clrwr_valid", 32'(bus0.o_valid), 32'h0);
    stat(0, "clrwr", 0, 0, 0);
    pop_exp(0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Overwrite mode: oldest two words are lost.
    for (int i = 0; i < 10; i++) drive(1, 1'b1, 8'(i), 1'b0, 1'b0);
    stat(1, "ovw_full", 8, 1, 2);
    for (int i = 2; i < 10; i++) pop_exp(1, 1'b1, 8'(i), 1'b0, 8'h00);
    stat(1, "ovw_end", 0, 1, 2);

    // Asynchronous reset between clock edges.
    drive(0, 1'b1, 8'h66, 1'b0, 1'b0);
    drive(0, 1'b1, 8'h67, 1'b0, 1'b0);
    pop_exp(0, 1'b1, 8'h66, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data",  32'(bus0.o_data),  32'h0);
    check("arst_valid", 32'(bus0.o_valid), 32'h0);
    stat(0, "arst", 0, 0, 0);
    stat(1, "arst1", 0, 0, 0);
    @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
